// File: rtl/imem_arb_pkg.sv
// Shared types and width helpers for the instruction-memory line arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of the word-offset field inside a cache line.
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Width of an encoded requester id.
  function automatic int id_w(input int num_req);
    return $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter import imem_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [id_w(N)-1:0]  ptr,
  output logic [N-1:0]        gnt,
  output logic [id_w(N)-1:0]  gnt_idx
);

  localparam int IW = id_w(N);

  // Scan offsets from highest to lowest so the nearest requester to ptr wins last.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt     = N'(1) << idx;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/imem_line_arbiter.sv
// Round-robin line-fill arbiter in front of a single-port instruction memory.
// Grants one requester, bursts LINE_WORDS reads for its line, and streams the
// returned words back tagged with id/beat/last.
// Optional: define IMEM_ARB_CRIT_WORD_EN to start each burst at the requested
// word and wrap within the line (critical word first).
module imem_line_arbiter import imem_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [id_w(NUM_REQ)-1:0]      rsp_id,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [off_w(LINE_WORDS)-1:0]  rsp_beat,
  output logic                          rsp_last,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic                          busy,
  output logic                          err_ack
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CW    = OFF_W + 1;
  localparam logic [CW-1:0]     RX_FULL  = CW'(LINE_WORDS);
  localparam logic [CW-1:0]     RX_LAST  = CW'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0]  TX_LAST  = OFF_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS - 1);

  state_t              state, state_nx;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     id;
  logic [ADDR_W-1:0]   base;
  logic [OFF_W-1:0]    start;
  logic [OFF_W-1:0]    tx_beat;
  logic [OFF_W-1:0]    tx_cnt;
  logic [CW-1:0]       rx_cnt;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [OFF_W-1:0]    start_nx;
  logic                grant;
  logic                in_win;
  logic                acc;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Pick the winning requester's address slot.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_idx == ID_W'(i)) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
  end

`ifdef IMEM_ARB_CRIT_WORD_EN
  assign start_nx = sel_addr[OFF_W-1:0];
`else
  assign start_nx = '0;
`endif

  // Handshake, memory request and response pass-through; all gated off during rst.
  always_comb begin
    grant     = (state == IDLE) && !rst && (|req_valid);
    req_ready = grant ? gnt : '0;
    in_win    = ((state == ISSUE) || (state == DRAIN)) && (rx_cnt < RX_FULL);
    acc       = mem_ack && in_win && !rst;
    rsp_valid = acc;
    rsp_id    = acc ? id : '0;
    rsp_data  = acc ? mem_rdata : '0;
    rsp_beat  = acc ? (start + rx_cnt[OFF_W-1:0]) : '0;
    rsp_last  = acc && (rx_cnt == RX_LAST);
    mem_req   = (state == ISSUE) && !rst;
    mem_addr  = mem_req ? (base | ADDR_W'(tx_beat)) : '0;
    busy      = (state != IDLE);
  end

  // Next-state: one line per grant, drain until the last beat's ack returns.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   if (tx_cnt == TX_LAST) state_nx = DRAIN;
      DRAIN:   if (acc && (rx_cnt == RX_LAST)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, round-robin pointer, line context and beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      id      <= '0;
      base    <= '0;
      start   <= '0;
      tx_beat <= '0;
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      err_ack <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        id      <= gnt_idx;
        base    <= sel_addr & ~OFF_MASK;
        start   <= start_nx;
        tx_beat <= start_nx;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
      end
      if (state == ISSUE) begin
        tx_beat <= tx_beat + 1'b1;
        tx_cnt  <= tx_cnt + 1'b1;
      end
      if (acc) rx_cnt <= rx_cnt + 1'b1;
      // An ack with nothing outstanding is dropped but remembered.
      if (mem_ack && !in_win) err_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_line_arbiter.sv
// Scoreboard bench for imem_line_arbiter: expected memory addresses and
// responses are queued at each grant and popped as the DUT produces them.
module tb_imem_line_arbiter;

  localparam int NR = 4;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int LW = 8;
`ifdef IMEM_ARB_CRIT_WORD_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [2:0]        rsp_beat;
  logic              rsp_last;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              err_ack;

  logic              ack_q = 1'b0;
  logic [DW-1:0]     rdata_q = '0;
  logic              spur;
  logic [31:0]       cyc = 0;
  int                n_chk = 0;
  int                n_err = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic [2:0]  beat;
    logic        last;
    logic [31:0] cyc;
  } rsp_t;

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] cyc;
  } areq_t;

  rsp_t  rq[$];
  areq_t aq[$];
  int    glog_id[$];
  int    glog_cyc[$];

  imem_line_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_beat(rsp_beat), .rsp_last(rsp_last),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .err_ack(err_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read, ack one cycle after req.
  always @(posedge clk) begin
    ack_q   <= mem_req;
    rdata_q <= {12'h0, mem_addr} ^ 32'hA5A5_0000;
  end
  assign mem_ack   = ack_q | spur;
  assign mem_rdata = rdata_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: log grants, build expectations, compare memory requests and responses.
  always @(negedge clk) begin : mon
    logic [3:0]  g;
    logic [19:0] ad, base, a;
    logic [2:0]  st, bt;
    int          gi;
    rsp_t        e;
    areq_t       ea;
    g = req_valid & req_ready;
    if (req_ready != 0) begin
      chk("ready_onehot", $countones(req_ready), 1);
      chk("ready_without_valid", |(req_ready & ~req_valid), 0);
    end
    if (g != 0) begin
      gi = 0;
      for (int i = 0; i < NR; i++) if (g[i]) gi = i;
      glog_id.push_back(gi);
      glog_cyc.push_back(int'(cyc));
      ad   = req_addr[gi*AW +: AW];
      base = ad & ~20'h7;
      st   = CRIT ? ad[2:0] : 3'd0;
      for (int b = 0; b < LW; b++) begin
        bt      = st + 3'(b);
        a       = base | {17'h0, bt};
        ea.addr = a;
        ea.cyc  = cyc + 1 + b;
        aq.push_back(ea);
        e.id    = 2'(gi);
        e.data  = {12'h0, a} ^ 32'hA5A5_0000;
        e.beat  = bt;
        e.last  = (b == LW - 1);
        e.cyc   = cyc + 2 + b;
        rq.push_back(e);
      end
    end
    if (mem_req) begin
      if (aq.size() == 0) chk("mem_req_unexpected", 1, 0);
      else begin
        ea = aq.pop_front();
        chk("mem_addr", mem_addr, ea.addr);
        chk("mem_req_cycle", cyc, ea.cyc);
      end
    end
    if (rsp_valid) begin
      if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_beat", rsp_beat, e.beat);
        chk("rsp_last", rsp_last, e.last);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_addr(input int i, input logic [19:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq.delete();
    aq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drop each requester once granted; optionally re-raise requester 0 when 1 is granted.
  task automatic run(input int maxc, input bit rearm);
    logic [3:0] g;
    bit armed;
    armed = rearm;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      g = req_valid & req_ready;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      if (armed && g[1]) begin
        req_valid[0] = 1'b1;
        armed = 1'b0;
      end
      if (req_valid == 0 && !busy && rq.size() == 0 && aq.size() == 0) return;
    end
    chk("run_timeout", 1, 0);
  endtask

  task automatic check_order(input string tag, input int exp_ids[$], input int gap);
    chk({tag, "_ngrants"}, glog_id.size(), exp_ids.size());
    for (int i = 0; i < exp_ids.size() && i < glog_id.size(); i++) begin
      chk({tag, "_gid"}, glog_id[i], exp_ids[i]);
      if (i > 0 && gap > 0) chk({tag, "_gap"}, glog_cyc[i] - glog_cyc[i-1], gap);
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_valid = '0; req_addr = '0; spur = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_beat", rsp_beat, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ack", err_ack, 0);

    // Single request from requester 1
    @(posedge clk); #1;
    set_addr(1, 20'h00123);
    glog_id.delete(); glog_cyc.delete();
    req_valid = 4'b0010;
    run(100, 1'b0);
    check_order("single", '{1}, 0);
    chk("single_busy_after", busy, 0);

    // All four from reset, requester 0 re-requests after its line
    do_reset();
    set_addr(0, 20'h00010); set_addr(1, 20'h00208);
    set_addr(2, 20'h12340); set_addr(3, 20'hFFFF8);
    glog_id.delete(); glog_cyc.delete();
    req_valid = 4'b1111;
    run(200, 1'b1);
    check_order("all4", '{0, 1, 2, 3, 0}, 10);

    // Requester 2 held continuously
    set_addr(2, 20'h00555);
    glog_id.delete(); glog_cyc.delete();
    req_valid = 4'b0100;
    repeat (35) @(posedge clk);
    #1 req_valid = 4'b0000;
    run(100, 1'b0);
    check_order("b2b", '{2, 2, 2, 2}, 10);

    // Reset on the 4th issue cycle
    do_reset();
    set_addr(1, 20'h00040); set_addr(2, 20'h00080);
    req_valid = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (req_ready[1]) seen = 1'b1;
    end
    chk("midrst_grant_seen", seen, 1);
    @(posedge clk); #1 req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rq.delete(); aq.delete();
    @(negedge clk);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_err_ack", err_ack, 0);
    repeat (5) @(posedge clk);
    #1;
    glog_id.delete(); glog_cyc.delete();
    req_valid = 4'b0110;
    run(100, 1'b0);
    check_order("midrst", '{1, 2}, 10);
    chk("midrst_err_ack_end", err_ack, 0);

    // Spurious ack in IDLE
    spur = 1'b1;
    @(negedge clk);
    chk("spur_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    chk("spur_err_ack", err_ack, 1);
    @(posedge clk); #1;
    set_addr(0, 20'h00300);
    req_valid = 4'b0001;
    run(100, 1'b0);
    chk("spur_err_sticky", err_ack, 1);
    do_reset();
    @(negedge clk);
    chk("spur_err_cleared", err_ack, 0);

    // Line with nonzero offset from requester 3 (wraps when critical-word-first)
    @(posedge clk); #1;
    set_addr(3, 20'h00406);
    glog_id.delete(); glog_cyc.delete();
    req_valid = 4'b1000;
    run(100, 1'b0);
    check_order("crit", '{3}, 0);
    chk("end_rq_empty", rq.size(), 0);
    chk("end_aq_empty", aq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
